// File: rtl/usb_reg_responder.sv
// Byte-stream command responder: 'W' addr data / 'R' addr over the CDC-ACM stream,
// backed by a 4x8 register file (reg3 read-only ID, reg0[2:0] drives the RGB LED).
module usb_reg_responder #(
  parameter logic [7:0] ID_VALUE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 48_000_000
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] regs,
  output logic [2:0]  led_rgb,
  output logic        timeout_err
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] REPLY_OK = 8'h4B;
  localparam logic [7:0] REPLY_ERR = 8'h3F;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_SEND
  } state_t;

  state_t        state, state_n;
  logic [7:0]    addr_q, addr_n;
  logic          wr_q, wr_n;
  logic [7:0]    reg0_q, reg0_n;
  logic [7:0]    reg1_q, reg1_n;
  logic [7:0]    reg2_q, reg2_n;
  logic [7:0]    reg3_q;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    tx_data_q, tx_data_n;
  logic          tx_valid_q, tx_valid_n;
  logic          rx_ready_q, rx_ready_n;

  logic accept;
  logic take;
  logic partial;
  logic expired;

  function automatic logic [7:0] read_reg(input logic [7:0] a, input logic [7:0] r0,
                                          input logic [7:0] r1, input logic [7:0] r2);
    case (a)
      8'd0:    return r0;
      8'd1:    return r1;
      8'd2:    return r2;
      8'd3:    return ID_VALUE;
      default: return REPLY_ERR;
    endcase
  endfunction

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= 8'h00;
      wr_q       <= 1'b0;
      reg0_q     <= 8'h00;
      reg1_q     <= 8'h00;
      reg2_q     <= 8'h00;
      reg3_q     <= 8'h00;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      wr_q       <= wr_n;
      reg0_q     <= reg0_n;
      reg1_q     <= reg1_n;
      reg2_q     <= reg2_n;
      // reg3 reads as zero while reset is held, then mirrors the constant ID.
      reg3_q     <= ID_VALUE;
      cnt_q      <= cnt_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      rx_ready_q <= rx_ready_n;
    end
  end

  assign accept  = rx_valid && rx_ready_q;
  assign take    = tx_valid_q && tx_ready;
  assign partial = (state == S_GET_ADDR) || (state == S_GET_DATA);
  // A byte arriving in the final cycle wins over the timeout.
  assign expired = partial && (cnt_q == CNT_LAST) && !accept;

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    wr_n       = wr_q;
    reg0_n     = reg0_q;
    reg1_n     = reg1_q;
    reg2_n     = reg2_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            wr_n    = (rx_data == OP_WRITE);
            state_n = S_GET_ADDR;
          end else begin
            tx_data_n  = REPLY_ERR;
            tx_valid_n = 1'b1;
            state_n    = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (accept) begin
          addr_n = rx_data;
          if (wr_q) begin
            state_n = S_GET_DATA;
          end else begin
            tx_data_n  = read_reg(rx_data, reg0_q, reg1_q, reg2_q);
            tx_valid_n = 1'b1;
            state_n    = S_SEND;
          end
        end else if (expired) begin
          state_n = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (accept) begin
          // Data byte is always consumed so a bad address never desynchronises framing.
          tx_data_n = (addr_q < 8'd3) ? REPLY_OK : REPLY_ERR;
          case (addr_q)
            8'd0:    reg0_n = rx_data;
            8'd1:    reg1_n = rx_data;
            8'd2:    reg2_n = rx_data;
            default: ;
          endcase
          tx_valid_n = 1'b1;
          state_n    = S_SEND;
        end else if (expired) begin
          state_n = S_IDLE;
        end
      end
      S_SEND: begin
        if (take) begin
          tx_valid_n = 1'b0;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    if (accept || expired || !partial) cnt_n = '0;
    else                               cnt_n = cnt_q + CW'(1);
  end

  assign rx_ready_n = (state_n != S_SEND);

  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign regs        = {reg3_q, reg2_q, reg1_q, reg0_q};
  assign led_rgb     = reg0_q[2:0];
  assign timeout_err = expired;

endmodule
